// File: rtl/borrow_lookahead_sub_pipe.sv
// -----------------------------------------------------------------------------
// borrow_lookahead_sub_pipe
//
// Pipelined subtractor D = A - B - Bin (mod 2^n). The operands are split into
// n/g groups of g bits. Pipeline stage k resolves group k with a
// borrow-lookahead network and hands its group borrow-out to stage k+1.
// Each stage has a valid/ready handshake, so the pipeline accepts one beat per
// cycle, applies full backpressure, and lets bubbles collapse.
//
// Parameters
//   n  operand/result width (a multiple of g, and at least g)
//   g  lookahead group width, which is the number of bits resolved per stage
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   pipeline can take a beat this cycle (combinational)
//   A, B       minuend / subtrahend
//   Bin        borrow-in
//   out_valid  result beat valid (registered)
//   out_ready  consumer takes the result beat
//   D          difference (registered)
//   Bout       unsigned borrow-out, 1 when A < B + Bin (registered)
//   V          signed overflow of A - B - Bin (registered)
// -----------------------------------------------------------------------------
module borrow_lookahead_sub_pipe #(
  parameter int n = 16,
  parameter int g = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] D,
  output logic         Bout,
  output logic         V
);

  localparam int L = n / g;

  // Subtracts one g-bit group. Returns {group borrow-out, g difference bits}.
  // Each bit's borrow-in is built as a flat sum of products over the generate
  // and propagate terms, not as a chain:
  //   b[i+1] = OR_j ( gen[j] & prop[j+1..i] )  |  ( bin & prop[0..i] )
  // This gives the same bits as the ripple recurrence b[i+1] = gen | prop & b[i].
  function automatic logic [g:0] group_sub(input logic [g-1:0] a,
                                           input logic [g-1:0] b,
                                           input logic         bin);
    logic [g-1:0] gen;
    logic [g-1:0] prop;
    logic [g:0]   bor;
    logic         term;
    gen  = ~a & b;
    prop = ~(a ^ b);
    bor  = '0;
    bor[0] = bin;
    for (int i = 0; i < g; i++) begin
      term = bin;
      for (int m = 0; m <= i; m++) term = term & prop[m];
      bor[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int m = j + 1; m <= i; m++) term = term & prop[m];
        bor[i+1] = bor[i+1] | term;
      end
    end
    return {bor[g], a ^ b ^ bor[g-1:0]};
  endfunction

  logic [L-1:0] valid_vec;
  logic [L:0]   ready;

  // A stage can take a new beat when it is empty, or when its own beat moves
  // on during the same cycle. The chain therefore resolves from the output
  // side back toward the input.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first; a path
    // that skips the assignment would infer a latch.
    ready    = '0;
    ready[L] = out_ready;
    for (int k = L - 1; k >= 0; k--) ready[k] = ~valid_vec[k] | ready[k+1];
  end

  assign in_ready = ready[0];

  for (genvar k = 0; k < L; k++) begin : g_stage
    // Values presented to this stage by its upstream neighbour.
    logic         pv;
    logic [n-1:0] pa;
    logic [n-1:0] pb;
    logic [n-1:0] pd;
    logic         pbor;
    // Result of resolving group k.
    logic [g:0]   grp;
    logic [n-1:0] nd;
    // Stage registers.
    logic         valid_q;
    logic [n-1:0] a_q;
    logic [n-1:0] b_q;
    logic [n-1:0] d_q;
    logic         bor_q;

    if (k == 0) begin : g_src
      assign pv   = in_valid;
      assign pa   = A;
      assign pb   = B;
      assign pd   = '0;
      assign pbor = Bin;
    end else begin : g_src
      assign pv   = g_stage[k-1].valid_q;
      assign pa   = g_stage[k-1].a_q;
      assign pb   = g_stage[k-1].b_q;
      assign pd   = g_stage[k-1].d_q;
      assign pbor = g_stage[k-1].bor_q;
    end

    always_comb begin
      grp = group_sub(pa[k*g +: g], pb[k*g +: g], pbor);
      nd  = pd;
      nd[k*g +: g] = grp[g-1:0];
    end

    // When the stage is not ready, it holds its beat and keeps every field
    // unchanged. When it is ready but nothing arrives, it turns into a bubble
    // and its stale data stays put.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the datapath registers are reset along with the valids, so the
      // outputs read zero as soon as reset asserts, not only once the valids clear.
      if (!rst_n) begin
        valid_q <= 1'b0;
        a_q     <= '0;
        b_q     <= '0;
        d_q     <= '0;
        bor_q   <= 1'b0;
      end else if (ready[k]) begin
        // NOTE: state updates use non-blocking assignments, so each stage
        // samples its neighbour's value from before the edge.
        valid_q <= pv;
        if (pv) begin
          a_q   <= pa;
          b_q   <= pb;
          d_q   <= nd;
          bor_q <= grp[g];
        end
      end
    end

    assign valid_vec[k] = valid_q;
  end

  // Overflow is formed while the last group resolves. This lets V come out of
  // a register, like D and Bout do.
  logic v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else if (ready[L-1] && g_stage[L-1].pv) begin
      v_q <= (g_stage[L-1].pa[n-1] ^ g_stage[L-1].pb[n-1]) &
             (g_stage[L-1].pa[n-1] ^ g_stage[L-1].nd[n-1]);
    end
  end

  assign out_valid = g_stage[L-1].valid_q;
  assign D         = g_stage[L-1].d_q;
  assign Bout      = g_stage[L-1].bor_q;
  assign V         = v_q;

  // The last stage has no downstream group, so its operand copies have no
  // reader. They are kept only so that every stage has the same structure.
  logic unused_tail;
  assign unused_tail = ^{g_stage[L-1].a_q, g_stage[L-1].b_q};

endmodule

// File: tb/tb_borrow_lookahead_sub_pipe.sv
// -----------------------------------------------------------------------------
// tb_borrow_lookahead_sub_pipe
//
// Self-checking bench with a scoreboard. An expected {Bout, V, D} value is
// pushed when a beat is accepted and popped when a result beat is taken.
// The main instance uses g=4. Two more instances, with g=8 and g=16, run a
// random regression in parallel.
// -----------------------------------------------------------------------------
module tb_borrow_lookahead_sub_pipe;

  localparam int N = 16;
  localparam int G = 4;
  localparam int L = N / G;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bout;
  logic        v;

  int total = 0;
  int bad   = 0;

  logic [17:0] sb[$];
  logic        prev_stall;
  logic [17:0] prev_out;
  logic        last_ov;
  logic        last_ir;
  logic        alt_go;
  logic [1:0]  alt_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  borrow_lookahead_sub_pipe #(.n(N), .g(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d),
    .Bout      (bout),
    .V         (v)
  );

  // Reference model: returns {borrow, overflow, difference}.
  function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
    logic [16:0] full;
    logic [15:0] df;
    full = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    df   = full[15:0];
    return {full[16], (x[15] ^ y[15]) & (x[15] ^ df[15]), df};
  endfunction

  // Runs one clock cycle on the main instance. Inputs are driven at posedge+1
  // and sampled at the negedge. Transfers are booked for the next posedge.
  task automatic cycle(input logic iv, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, input logic ordy, input logic [17:0] exp,
                       output logic took);
    logic [17:0] got;
    logic [17:0] want;
    logic        exp_ir;
    in_valid  = iv;
    a         = av;
    b         = bv;
    bin       = bi;
    out_ready = ordy;
    @(negedge clk);
    got     = {bout, v, d};
    last_ov = out_valid;
    last_ir = in_ready;
    // An empty stage anywhere in the pipeline lets a beat in.
    exp_ir = ordy | (sb.size() < L);
    total++;
    if (in_ready !== exp_ir) begin
      bad++;
      $display("FAIL in_ready: got %b want %b (in flight %0d)", in_ready, exp_ir, sb.size());
    end
    if (prev_stall) begin
      total++;
      if ({out_valid, got} !== {1'b1, prev_out}) begin
        bad++;
        $display("FAIL stall_hold: got ov=%b %h want ov=1 %h", out_valid, got, prev_out);
      end
    end
    if (out_valid !== 1'b0 && ordy) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got ov=%b %h want no output", out_valid, got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL result: got {bout,v,d}=%h want %h", got, want);
        end
      end
    end
    prev_stall = (out_valid === 1'b1) && !ordy;
    prev_out   = got;
    took       = iv && (in_ready === 1'b1);
    if (took) sb.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic t;
    for (int c = 0; c < 40 && sb.size() != 0; c++) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 18'd0, t);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d beats outstanding want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov: got %b want 0", out_valid); end
    if (d !== 16'h0000)     begin bad++; $display("FAIL reset_d: got %h want 0000", d); end
    if (bout !== 1'b0)      begin bad++; $display("FAIL reset_bout: got %b want 0", bout); end
    if (v !== 1'b0)         begin bad++; $display("FAIL reset_v: got %b want 0", v); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    logic took;
    int   edges;
    cycle(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, 18'h00002, took);
    total++;
    if (took !== 1'b1) begin bad++; $display("FAIL lat_accept: got %b want 1", took); end
    edges = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 18'd0, took);
      if (last_ov === 1'b1) begin edges = k; break; end
    end
    total++;
    if (edges != L) begin
      bad++;
      $display("FAIL latency: got %0d edges want %0d", edges, L);
    end
    drain();
  endtask

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        bi;
    logic [17:0] exp;
  } vec_t;

  task automatic test_vectors();
    vec_t vecs[6];
    logic took;
    vecs[0] = '{16'h0000, 16'h0001, 1'b0, 18'h2FFFF};
    vecs[1] = '{16'h1234, 16'h1234, 1'b1, 18'h2FFFF};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 18'h17FFF};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 18'h38000};
    vecs[4] = '{16'hABCD, 16'hABCD, 1'b0, 18'h00000};
    vecs[5] = '{16'h0005, 16'h0003, 1'b0, 18'h00002};
    foreach (vecs[i]) cycle(1'b1, vecs[i].x, vecs[i].y, vecs[i].bi, 1'b1, vecs[i].exp, took);
    drain();
  endtask

  task automatic test_back_to_back();
    int          sent;
    logic        saw_full;
    logic        took;
    logic        ordy;
    logic [15:0] x;
    logic [15:0] y;
    logic        bi;
    sent     = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 60 && (sent < 10 || sb.size() != 0); c++) begin
      ordy = !(c >= 3 && c < 9);
      x    = 16'($urandom);
      y    = 16'($urandom);
      bi   = 1'($urandom);
      cycle(sent < 10, x, y, bi, ordy, ref_sub(x, y, bi), took);
      if (last_ir === 1'b0) saw_full = 1'b1;
      if (took) sent++;
    end
    total += 3;
    if (sent != 10)      begin bad++; $display("FAIL bp_sent: got %0d want 10", sent); end
    if (saw_full !== 1'b1) begin bad++; $display("FAIL bp_full: got saw_full=%b want 1", saw_full); end
    if (sb.size() != 0)  begin bad++; $display("FAIL bp_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic took;
    logic seen;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'h1000 + 16'(i), 16'h0001, 1'b0, 1'b0, ref_sub(16'h1000 + 16'(i), 16'h0001, 1'b0), took);
    for (int i = 0; i < 2; i++) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 18'd0, took);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre: got ov=%b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_ov: got %b want 0", out_valid); end
    if (d !== 16'h0000)     begin bad++; $display("FAIL rm_d: got %h want 0000", d); end
    if (bout !== 1'b0)      begin bad++; $display("FAIL rm_bout: got %b want 0", bout); end
    if (v !== 1'b0)         begin bad++; $display("FAIL rm_v: got %b want 0", v); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
    sb.delete();
    prev_stall = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 18'd0, took);
      if (last_ov !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rm_stale: got out_valid after reset want none"); end
    cycle(1'b1, 16'h0100, 16'h0200, 1'b1, 1'b1, 18'h2FEFF, took);
    drain();
  endtask

  task automatic test_random();
    int          sent;
    logic        took;
    logic [15:0] x;
    logic [15:0] y;
    logic        bi;
    sent = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      x  = 16'($urandom);
      y  = 16'($urandom);
      bi = 1'($urandom);
      cycle($urandom_range(0, 3) != 0, x, y, bi, $urandom_range(0, 3) != 0, ref_sub(x, y, bi), took);
      if (took) sent++;
    end
    total++;
    if (sent != 10000) begin bad++; $display("FAIL rand_sent: got %0d want 10000", sent); end
    drain();
  endtask

  // Wider-group instances (g=8 -> L=2, g=16 -> L=1), each with its own
  // random producer, consumer and scoreboard.
  for (genvar gi = 0; gi < 2; gi++) begin : g_alt
    localparam int GW = (gi == 0) ? 8 : 16;
    localparam int LL = N / GW;
    logic        iv;
    logic        ir;
    logic        ov;
    logic        ordy;
    logic        bi;
    logic        bo;
    logic        vv;
    logic [15:0] xa;
    logic [15:0] xb;
    logic [15:0] xd;
    logic [17:0] q[$];

    borrow_lookahead_sub_pipe #(.n(N), .g(GW)) u_alt (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .A         (xa),
      .B         (xb),
      .Bin       (bi),
      .out_valid (ov),
      .out_ready (ordy),
      .D         (xd),
      .Bout      (bo),
      .V         (vv)
    );

    initial begin
      int          sent;
      logic        ps;
      logic [17:0] po;
      logic [17:0] got;
      logic [17:0] want;
      iv = 1'b0; ordy = 1'b0; xa = '0; xb = '0; bi = 1'b0;
      sent = 0; ps = 1'b0; po = '0;
      wait (alt_go === 1'b1);
      @(posedge clk);
      #1;
      for (int c = 0; c < 40000 && (sent < 3000 || q.size() != 0); c++) begin
        iv   = (sent < 3000) && ($urandom_range(0, 3) != 0);
        ordy = (sent >= 3000) || ($urandom_range(0, 3) != 0);
        xa   = 16'($urandom);
        xb   = 16'($urandom);
        bi   = 1'($urandom);
        @(negedge clk);
        got = {bo, vv, xd};
        total++;
        if (ir !== (ordy | (q.size() < LL))) begin
          bad++;
          $display("FAIL alt%0d_in_ready: got %b want %b", GW, ir, ordy | (q.size() < LL));
        end
        if (ps) begin
          total++;
          if ({ov, got} !== {1'b1, po}) begin
            bad++;
            $display("FAIL alt%0d_stall_hold: got ov=%b %h want ov=1 %h", GW, ov, got, po);
          end
        end
        if (ov !== 1'b0 && ordy) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL alt%0d_unexpected_out: got %h want no output", GW, got);
          end else begin
            want = q.pop_front();
            if (got !== want) begin
              bad++;
              $display("FAIL alt%0d_result: got %h want %h", GW, got, want);
            end
          end
        end
        ps = (ov === 1'b1) && !ordy;
        po = got;
        if (iv && ir === 1'b1) begin
          q.push_back(ref_sub(xa, xb, bi));
          sent++;
        end
        @(posedge clk);
        #1;
      end
      total++;
      if (sent != 3000 || q.size() != 0) begin
        bad++;
        $display("FAIL alt%0d_count: got sent=%0d left=%0d want 3000/0", GW, sent, q.size());
      end
      alt_done[gi] = 1'b1;
    end
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    bin        = 1'b0;
    out_ready  = 1'b1;
    prev_stall = 1'b0;
    prev_out   = '0;
    last_ov    = 1'b0;
    last_ir    = 1'b1;
    alt_go     = 1'b0;
    alt_done   = 2'b00;
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    alt_go = 1'b1;
    test_random();
    for (int c = 0; c < 50000 && alt_done !== 2'b11; c++) @(posedge clk);
    total++;
    if (alt_done !== 2'b11) begin
      bad++;
      $display("FAIL alt_timeout: got done=%b want 11", alt_done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/borrow_lookahead_sub_pipe.md
# borrow_lookahead_sub_pipe

Pipelined n-bit subtractor that computes D = A − B − Bin using grouped borrow-lookahead logic. It is the subtraction counterpart to the team's carry-lookahead adder. Each pipeline stage resolves one g-bit group and passes the group borrow-out to the next stage. A valid/ready handshake on both sides gives one result per cycle with full backpressure. It sits between operand producers and any datapath consumer that needs difference, borrow and signed-overflow flags.

## Interface
Parameters:
- n, 16, operand and result width; must be a multiple of g and at least g.
- g, 4, lookahead group width, i.e. bits resolved per pipeline stage.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operand beat is valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- A  input  n  minuend, unsigned or two's complement.
- B  input  n  subtrahend.
- Bin  input  1  borrow-in, for chaining wider subtractions.
- out_valid  output  1  result beat is valid.
- out_ready  input  1  consumer accepts the result beat.
- D  output  n  difference, A − B − Bin mod 2^n.
- Bout  output  1  borrow-out: 1 when A < B + Bin, unsigned.
- V  output  1  signed overflow of A − B − Bin.

## Operation
- Pipeline depth L = n/g stages. Each stage k holds:
  - valid_k;
  - difference bits [g·k−1:0] already resolved;
  - the remaining upper A/B bits;
  - the running borrow;
  - A[n−1] and B[n−1] for the overflow calculation.
- Stage k computes group k with these per-bit terms:
  - generate Gb = ~A & B;
  - propagate Pb = ~(A ^ B);
  - d = A ^ B ^ b_in;
  - b_out = Gb | (Pb & b_in).
- Group borrow is computed in lookahead form over the g bits, not as a ripple chain. The result must be bit-identical to the ripple form.
- Stage 0 takes Bin as its borrow-in.
- Final stage:
  - Bout = borrow out of bit n−1;
  - V = (A[n−1] ^ B[n−1]) & (A[n−1] ^ D[n−1]).
- Handshake:
  - A beat transfers when valid & ready on the same edge.
  - Per-stage ready: ready_k = ~valid_k | ready_{k+1}, where ready_L = out_ready.
  - in_ready = ready_0, combinational from out_ready and the stage valids.
- A stage that holds a beat and cannot advance keeps all its contents unchanged.
- Results emerge in acceptance order. No beat is dropped or duplicated.
- out_valid, D, Bout and V come directly from final-stage registers.
  - They stay stable while out_valid=1 and out_ready=0.
- Reset (rst_n=0, asynchronous):
  - all valid_k = 0;
  - all datapath registers = 0;
  - out_valid = 0, D = 0, Bout = 0, V = 0;
  - in_ready = 1 while held in reset and after release, because the pipeline is empty.
- Reset mid-operation discards every in-flight beat. No stale result appears after release.

## Timing
- Latency: a beat accepted on edge t appears with out_valid=1 after edge t+L−1. For L=4, that is the 4th edge counting the accept edge.
- Throughput: one beat per cycle while out_ready=1.
- Full pipeline (all L valid) with out_ready=0: in_ready=0 in the same cycle.
- out_ready=1 with the pipeline full: in_ready=1 in the same cycle, so a simultaneous accept and emit occurs with no bubble.
- Bubbles collapse: with out_ready=0, an upstream beat may advance into an empty downstream stage.
- Edge cases:
  - A=B with Bin=0 gives D=0, Bout=0, V=0.
  - Bin=1 with A=B gives D=all ones, Bout=1.

## Test plan
Defaults: n=16, g=4, L=4, out_ready=1 unless stated.
- A=0x0005, B=0x0003, Bin=0 → D=0x0002, Bout=0, V=0, with out_valid on the 4th edge after accept.
- A=0x0000, B=0x0001, Bin=0 → D=0xFFFF, Bout=1, V=0. A=0x1234, B=0x1234, Bin=1 → D=0xFFFF, Bout=1, V=0.
- A=0x8000, B=0x0001 → D=0x7FFF, Bout=0, V=1. A=0x7FFF, B=0xFFFF → D=0x8000, Bout=1, V=1.
- Backpressure: 10 back-to-back random beats, with out_ready held 0 for 6 cycles mid-stream.
  - in_ready drops when 4 beats are held.
  - Outputs are stable while stalled.
  - All 10 results are correct and in order.
- Reset mid-stream: accept 3 beats, pull rst_n low asynchronously between edges.
  - out_valid, D, Bout and V go to 0 immediately.
  - After release, no output appears until a new beat is accepted.
- Random regression: 10k beats with random in_valid/out_ready and random Bin, compared against a reference model (A − B − Bin) mod 2^16 with borrow and overflow. Repeat with g=8 and g=16 (L=2 and L=1).
